// File: rtl/recip_quotient_seq.sv
// recip_quotient_seq: turns a dividend, a divisor and the divisor's
// fixed-point reciprocal into an exact quotient and remainder.
// Phases: A*rec estimate (shift-add), q_est*B back-multiply (shift-add),
// then one correction step, because q_est is always q or q-1.
module recip_quotient_seq #(
    parameter int ARG_BIT_WIDTH = 32,
    parameter int PRECISION     = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [ARG_BIT_WIDTH-1:0] A,
    input  logic [ARG_BIT_WIDTH-1:0] B,
    input  logic [PRECISION-1:0]     rec,
    input  logic                     dvz,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ARG_BIT_WIDTH-1:0] quot,
    output logic [ARG_BIT_WIDTH-1:0] rem,
    output logic                     dz
);

    localparam int ACC_W = ARG_BIT_WIDTH + PRECISION;
    localparam int CNT_W = $clog2(ARG_BIT_WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ARG_BIT_WIDTH - 1);
    localparam logic [ARG_BIT_WIDTH-1:0] ONE = ARG_BIT_WIDTH'(1);

    // The reciprocal must carry exactly twice the operand width of fraction bits.
    generate
        if (PRECISION != 2 * ARG_BIT_WIDTH) begin : g_bad_precision
            $error("recip_quotient_seq: PRECISION must equal 2*ARG_BIT_WIDTH");
        end
    endgenerate

    typedef enum logic [2:0] {S_IDLE, S_MUL, S_MULB, S_FIX, S_DONE} state_t;

    state_t                   r_state;
    state_t                   w_state_next;
    logic [CNT_W-1:0]         r_cnt;
    logic [ARG_BIT_WIDTH-1:0] r_a;
    logic [ARG_BIT_WIDTH-1:0] r_b;
    logic [ACC_W-1:0]         r_acc;
    logic [ACC_W-1:0]         r_mcand;
    logic [ARG_BIT_WIDTH-1:0] r_mplier;
    logic [ARG_BIT_WIDTH-1:0] r_qest;
    logic [ARG_BIT_WIDTH:0]   r_rest;
    logic [ARG_BIT_WIDTH-1:0] r_quot;
    logic [ARG_BIT_WIDTH-1:0] r_rem;
    logic                     r_dz;
    logic                     r_out_valid;

    logic                     w_accept;
    logic                     w_zero_div;
    logic                     w_wrap;
    logic [ACC_W-1:0]         w_acc_next;
    logic [ARG_BIT_WIDTH-1:0] w_prod_hi;
    logic [ARG_BIT_WIDTH-1:0] w_prod_lo;
    logic                     w_rest_ge_b;

    assign w_accept    = in_valid && (r_state == S_IDLE);
    assign w_zero_div  = dvz || (B == '0);
    assign w_wrap      = (r_cnt == CNT_LAST);
    assign w_acc_next  = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign w_prod_hi   = w_acc_next[ACC_W-1:PRECISION];
    assign w_prod_lo   = w_acc_next[ARG_BIT_WIDTH-1:0];
    assign w_rest_ge_b = (r_rest >= {1'b0, r_b});

    assign quot = r_quot;
    assign rem  = r_rem;
    assign dz   = r_dz;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    // Next-state logic: each multiply phase runs one counter lap.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (in_valid) w_state_next = w_zero_div ? S_DONE : S_MUL;
            S_MUL:   if (w_wrap) w_state_next = S_MULB;
            S_MULB:  if (w_wrap) w_state_next = S_FIX;
            S_FIX:   w_state_next = S_DONE;
            S_DONE:  if (r_out_valid && out_ready) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Handshake outputs.
    always_comb begin
        in_ready  = (r_state == S_IDLE);
        out_valid = r_out_valid;
    end

    // Datapath: operand capture, the two shift-add loops, correction and result hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_acc       <= '0;
            r_mcand     <= '0;
            r_mplier    <= '0;
            r_qest      <= '0;
            r_rest      <= '0;
            r_quot      <= '0;
            r_rem       <= '0;
            r_dz        <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_a      <= A;
                        r_b      <= B;
                        r_mcand  <= {{ARG_BIT_WIDTH{1'b0}}, rec};
                        r_mplier <= A;
                        r_acc    <= '0;
                        r_cnt    <= '0;
                        if (w_zero_div) begin
                            r_quot <= '1;
                            r_rem  <= A;
                            r_dz   <= 1'b1;
                        end
                    end
                end
                S_MUL, S_MULB: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (!w_wrap) begin
                        r_acc    <= w_acc_next;
                        r_mcand  <= r_mcand << 1;
                        r_mplier <= r_mplier >> 1;
                    end else if (r_state == S_MUL) begin
                        // Estimate done: reload the multiplier pair with q_est and B.
                        r_qest   <= w_prod_hi;
                        r_acc    <= '0;
                        r_mcand  <= {{PRECISION{1'b0}}, r_b};
                        r_mplier <= w_prod_hi;
                    end else begin
                        // q_est*B never exceeds A, so this cannot go negative.
                        r_rest <= {1'b0, r_a} - {1'b0, w_prod_lo};
                    end
                end
                S_FIX: begin
                    r_dz <= 1'b0;
                    if (w_rest_ge_b) begin
                        r_quot <= r_qest + ONE;
                        r_rem  <= r_rest[ARG_BIT_WIDTH-1:0] - r_b;
                    end else begin
                        r_quot <= r_qest;
                        r_rem  <= r_rest[ARG_BIT_WIDTH-1:0];
                    end
                end
                S_DONE: begin
                    if (!r_out_valid)   r_out_valid <= 1'b1;
                    else if (out_ready) r_out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Operands may only be taken while idle.
    a_accept_idle: assert property (@(posedge clk) disable iff (!rst_n)
        (in_valid && in_ready) |-> (r_state == S_IDLE));

endmodule
